mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting two requesters access to one memory port.
// Misaligned accesses never reach memory and complete with an error ack.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic we_r, id_r, last, grant, win, bad;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  always_comb begin
    grant = state == IDLE && (req0 || req1);
    win = (req0 && req1) ? ~last : req1;
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    bad = |addr_r[1:0];
    mem_en = state == ACCESS && !bad;
    mem_we = mem_en && we_r;
    mem_addr = state == ACCESS ? addr_r >> 2 : '0;
    mem_wdata = state == ACCESS ? wdata_r : '0;
    ack0 = state == RESP && !id_r;
    ack1 = state == RESP && id_r;
    err0 = ack0 && bad;
    err1 = ack1 && bad;
    rdata0 = (ack0 && !bad) ? mem_rdata : '0;
    rdata1 = (ack1 && !bad) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      we_r <= 1'b0;
      id_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last <= win;
        id_r <= win;
        we_r <= win ? we1 : we0;
        addr_r <= win ? addr1 : addr0;
        wdata_r <= win ? wdata1 : wdata0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; a transaction-level model predicts memory strobes and acks.
module tb_mem_arbiter;
  logic clk, rst, req0, req1, we0, we1, ack0, ack1, err0, err1, mem_en, mem_we;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  typedef struct {logic port; logic err; logic we; logic [31:0] rdata; int cyc;} ack_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int cyc;} mem_t;
  ack_t ackq[$];
  mem_t memq[$];
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  int checks = 0, fails = 0, cyc = 0, free_at = 0;
  logic last;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] iv(int i);
    return i == 4 ? 32'hDEADBEEF : 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  initial for (int i = 0; i < 256; i++) begin
    ram[i] = iv(i);
    ref_mem[i] = iv(i);
  end

  // memory with one cycle of read latency
  always @(posedge clk) if (mem_en) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // reference model: one transaction per grant, busy for three cycles, memory strobe one
  // cycle after the grant and ack the cycle after that
  always @(posedge clk) begin
    logic w, wr, bad;
    logic [31:0] a, d;
    ack_t ea;
    mem_t em;
    cyc++;
    if (rst) begin
      ackq.delete();
      memq.delete();
      last = 1'b1;
      free_at = cyc + 1;
    end else if (cyc >= free_at && (req0 || req1)) begin
      if (req0 && req1) w = (last == 1'b0); else w = req1;
      a = w ? addr1 : addr0;
      wr = w ? we1 : we0;
      d = w ? wdata1 : wdata0;
      bad = a % 4 != 0;
      last = w;
      free_at = cyc + 3;
      ea.port = w; ea.err = bad; ea.we = wr; ea.cyc = cyc + 1;
      ea.rdata = bad ? 32'h0 : ref_mem[a[9:2]];
      ackq.push_back(ea);
      if (!bad) begin
        em.we = wr; em.addr = a / 4; em.wdata = d; em.cyc = cyc;
        memq.push_back(em);
        if (wr) ref_mem[a[9:2]] = d;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    ack_t e;
    mem_t m;
    chk("ack_exclusive", {63'h0, ack0 && ack1}, 64'h0);
    if (!ack0) chk("idle_port0_outputs", {31'h0, err0, rdata0}, 64'h0);
    if (!ack1) chk("idle_port1_outputs", {31'h0, err1, rdata1}, 64'h0);
    while (ackq.size() > 0 && ackq[0].cyc < cyc) begin
      checks++; fails++;
      $display("FAIL ack_missing: got none expected ack%0d at cycle %0d", ackq[0].port, ackq[0].cyc);
      void'(ackq.pop_front());
    end
    while (memq.size() > 0 && memq[0].cyc < cyc) begin
      checks++; fails++;
      $display("FAIL mem_missing: got none expected mem_en addr %0h at cycle %0d", memq[0].addr, memq[0].cyc);
      void'(memq.pop_front());
    end
    if (ack0 || ack1) begin
      if (ackq.size() == 0 || ackq[0].cyc != cyc) begin
        checks++; fails++;
        $display("FAIL ack_unexpected: got ack0=%0b ack1=%0b expected none at cycle %0d", ack0, ack1, cyc);
      end else begin
        e = ackq.pop_front();
        chk("ack_port", {63'h0, ack1}, {63'h0, e.port});
        chk("ack_err", {63'h0, e.port ? err1 : err0}, {63'h0, e.err});
        if (!e.we || e.err) chk("ack_rdata", {32'h0, e.port ? rdata1 : rdata0}, {32'h0, e.rdata});
      end
    end
    if (mem_en) begin
      if (memq.size() == 0 || memq[0].cyc != cyc) begin
        checks++; fails++;
        $display("FAIL mem_unexpected: got mem_en addr %0h expected none at cycle %0d", mem_addr, cyc);
      end else begin
        m = memq.pop_front();
        chk("mem_we", {63'h0, mem_we}, {63'h0, m.we});
        chk("mem_addr", {32'h0, mem_addr}, {32'h0, m.addr});
        if (m.we) chk("mem_wdata", {32'h0, mem_wdata}, {32'h0, m.wdata});
      end
    end else chk("mem_we_idle", {63'h0, mem_we}, 64'h0);
  end

  task automatic set_port(input logic p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  task automatic wait_ack(input logic p);
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) break;
    end
    checks++;
    if (t == 50) begin
      fails++;
      $display("FAIL ack_timeout: got no ack%0d expected one within 50 cycles", p);
    end
  endtask

  task automatic wait_acks(input int n);
    int got = 0;
    for (int t = 0; t < 60 && got < n; t++) begin
      @(negedge clk);
      if (ack0 || ack1) got++;
    end
    chk("ack_count", 64'(got), 64'(n));
  endtask

  task automatic do_req(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
    set_port(p, 1, w, a, d);
    wait_ack(p);
    @(posedge clk); #2;
    set_port(p, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic rnd(input logic p, input int n);
    int gap;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        set_port(p, 0, 0, 0, 0);
        repeat (gap) begin @(posedge clk); #2; end
      end
      a = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      set_port(p, 1, 1'($urandom_range(0, 1)), a, $urandom);
      wait_ack(p);
      @(posedge clk); #2;
    end
    set_port(p, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {54'h0, ack0, ack1, err0, err1, mem_en, mem_we, |rdata0, |rdata1, |mem_addr, |mem_wdata}, 64'h0);
    @(posedge clk); #2 rst = 0;
    do_req(0, 0, 32'h10, 0);
    do_req(1, 1, 32'h20, 32'h12345678);
    do_req(0, 0, 32'h20, 0);
    do_req(0, 0, 32'h13, 0);
    do_req(0, 1, 32'h17, 32'hFFFF0000);
    do_req(0, 0, 32'h14, 0);
    // both requesters held: grants must alternate starting with port 0
    do_reset();
    set_port(0, 1, 0, 32'h30, 0);
    set_port(1, 1, 0, 32'h34, 0);
    wait_acks(4);
    @(posedge clk); #2;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    // reset lands while a port-1 write is in its memory cycle
    do_reset();
    set_port(1, 1, 1, 32'h40, 32'hA5A5A5A5);
    @(posedge clk); #2;
    rst = 1;
    set_port(1, 0, 0, 0, 0);
    @(posedge clk); #2 rst = 0;
    repeat (4) begin @(posedge clk); #2; end
    set_port(0, 1, 0, 32'h50, 0);
    set_port(1, 1, 0, 32'h54, 0);
    wait_acks(2);
    @(posedge clk); #2;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    // request fields changed while the access is in flight
    set_port(0, 1, 1, 32'h44, 32'hCAFEF00D);
    @(posedge clk); #2;
    addr0 = 32'h48;
    we0 = 0;
    wait_ack(0);
    @(posedge clk); #2;
    set_port(0, 0, 0, 0, 0);
    do_req(0, 0, 32'h44, 0);
    do_req(0, 0, 32'h48, 0);
    fork
      rnd(0, 40);
      rnd(1, 40);
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("ackq_drained", 64'(ackq.size()), 64'h0);
    chk("memq_drained", 64'(memq.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
